// File: rtl/ieee488_device_if.sv
// IEEE-488 device-side bundle: wire-level bus lines plus the rx/tx byte streams and status.
// Latency: none, signal container only.
// Backpressure: rx uses rx_valid/rx_ready; tx uses tx_valid with a tx_ready completion pulse.
interface ieee488_device_if;
    // bus lines, wire level (0 = asserted)
    logic [7:0] ieee488_data_i;
    logic [7:0] ieee488_data_o;
    logic       ieee488_atn_i;
    logic       ieee488_ifc_i;
    logic       ieee488_dav_i;
    logic       ieee488_eoi_i;
    logic       ieee488_nrfd_i;
    logic       ieee488_ndac_i;
    logic       ieee488_dav_o;
    logic       ieee488_eoi_o;
    logic       ieee488_nrfd_o;
    logic       ieee488_ndac_o;
    // receive stream towards the drive model
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_eoi;
    logic       rx_atn;
    logic       rx_ready;
    // transmit stream from the drive model
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_eoi;
    logic       tx_ready;
    // addressing status
    logic       listening;
    logic       talking;
    logic       no_listener;
`ifdef IEEE488_SRQ_EN
    logic       srq_req;
    logic       ieee488_srq_o;
`endif

    modport slave (
        input  ieee488_data_i, ieee488_atn_i, ieee488_ifc_i, ieee488_dav_i,
               ieee488_eoi_i, ieee488_nrfd_i, ieee488_ndac_i,
               rx_ready, tx_valid, tx_data, tx_eoi,
`ifdef IEEE488_SRQ_EN
               srq_req,
        output ieee488_srq_o,
`endif
        output ieee488_data_o, ieee488_dav_o, ieee488_eoi_o, ieee488_nrfd_o, ieee488_ndac_o,
               rx_valid, rx_data, rx_eoi, rx_atn, tx_ready,
               listening, talking, no_listener
    );

    modport master (
        output ieee488_data_i, ieee488_atn_i, ieee488_ifc_i, ieee488_dav_i,
               ieee488_eoi_i, ieee488_nrfd_i, ieee488_ndac_i,
               rx_ready, tx_valid, tx_data, tx_eoi,
`ifdef IEEE488_SRQ_EN
               srq_req,
        input  ieee488_srq_o,
`endif
        input  ieee488_data_o, ieee488_dav_o, ieee488_eoi_o, ieee488_nrfd_o, ieee488_ndac_o,
               rx_valid, rx_data, rx_eoi, rx_atn, tx_ready,
               listening, talking, no_listener
    );
endinterface

// File: rtl/ieee488_device.sv
// IEEE-488 peripheral: listener/talker addressing, acceptor and source handshakes; optional SRQ via IEEE488_SRQ_EN.
// Latency: bus inputs pass a 2-flop synchroniser; all outputs registered, so bus-to-output reaction is 3 clk.
// Backpressure: a full rx buffer holds NRFD low (except under ATN); talking waits on NRFD/NDAC from listeners.
module ieee488_device #(
    parameter int DEV_ADDR      = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    ieee488_device_if.slave bus
);
    localparam logic [7:0] LAG = 8'(8'h20 + DEV_ADDR);
    localparam logic [7:0] TAG = 8'(8'h40 + DEV_ADDR);
    localparam logic [7:0] UNL = 8'h3F;

    typedef enum logic [1:0] {A_IDLE, A_READY, A_ACCEPT, A_WAITREL} ah_state_t;
    typedef enum logic [2:0] {S_IDLE, S_WAITNRFD, S_SETTLE, S_DAV, S_RELEASE} sh_state_t;

    ah_state_t  ah_state;
    sh_state_t  sh_state;
    logic [7:0] data_m, data_s;
    logic [5:0] ctl_m, ctl_s;
    logic       atn_act, ifc_act, dav_s, eoi_s, nrfd_s, ndac_s;
    logic       atn_prev, ah_active, rx_free, sh_run;
    logic [7:0] cap_data;
    logic       cap_eoi;
    logic       nrfd_r, ndac_r, dav_r, eoi_r;
    logic [7:0] data_o_r;
    logic       rx_valid_r, rx_eoi_r, rx_atn_r;
    logic [7:0] rx_data_r;
    logic       listening_r, talking_r, tx_ready_r, no_listener_r;
    logic [7:0] cnt;
`ifdef IEEE488_SRQ_EN
    logic       tag_hit, srq_req_q, srq_pend, srq_r;
`endif

    // Two-flop synchronisers on every bus input; idle (released) level on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_m <= 8'hFF;
            data_s <= 8'hFF;
            ctl_m  <= 6'h3F;
            ctl_s  <= 6'h3F;
        end else begin
            data_m <= bus.ieee488_data_i;
            data_s <= data_m;
            ctl_m  <= {bus.ieee488_atn_i, bus.ieee488_ifc_i, bus.ieee488_dav_i,
                       bus.ieee488_eoi_i, bus.ieee488_nrfd_i, bus.ieee488_ndac_i};
            ctl_s  <= ctl_m;
        end
    end

    assign atn_act   = ~ctl_s[5];
    assign ifc_act   = ~ctl_s[4];
    assign dav_s     = ctl_s[3];
    assign eoi_s     = ctl_s[2];
    assign nrfd_s    = ctl_s[1];
    assign ndac_s    = ctl_s[0];
    assign ah_active = atn_act || listening_r;
    // buffer is empty now or is being drained this cycle
    assign rx_free   = !rx_valid_r || bus.rx_ready;
    assign sh_run    = talking_r && !atn_act;

    // Acceptor handshake, command decode and the one-entry rx buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ah_state    <= A_IDLE;
            nrfd_r      <= 1'b1;
            ndac_r      <= 1'b1;
            atn_prev    <= 1'b0;
            listening_r <= 1'b0;
            talking_r   <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_eoi_r    <= 1'b0;
            rx_atn_r    <= 1'b0;
            cap_data    <= 8'h00;
            cap_eoi     <= 1'b0;
`ifdef IEEE488_SRQ_EN
            tag_hit     <= 1'b0;
`endif
        end else begin
            atn_prev <= atn_act;
`ifdef IEEE488_SRQ_EN
            tag_hit  <= 1'b0;
`endif
            if (rx_valid_r && bus.rx_ready)
                rx_valid_r <= 1'b0;
            if (ifc_act) begin
                ah_state    <= A_IDLE;
                nrfd_r      <= 1'b1;
                ndac_r      <= 1'b1;
                listening_r <= 1'b0;
                talking_r   <= 1'b0;
                rx_valid_r  <= 1'b0;
            end else if (!ah_active) begin
                ah_state <= A_IDLE;
                nrfd_r   <= 1'b1;
                ndac_r   <= 1'b1;
            end else if (ah_state == A_IDLE || atn_act != atn_prev) begin
                // fresh start or ATN flipped mid-byte: drop any half-captured byte
                ah_state <= A_READY;
                ndac_r   <= 1'b0;
                nrfd_r   <= atn_act || rx_free;
            end else begin
                case (ah_state)
                    A_READY: begin
                        if (!dav_s && nrfd_r) begin
                            cap_data <= ~data_s;
                            cap_eoi  <= ~eoi_s;
                            nrfd_r   <= 1'b0;
                            ah_state <= A_ACCEPT;
                        end else begin
                            nrfd_r <= atn_act || rx_free;
                        end
                    end
                    A_ACCEPT: begin
                        ah_state <= A_WAITREL;
                        ndac_r   <= 1'b1;
                        nrfd_r   <= 1'b0;
                        if (atn_act) begin
                            if (cap_data == LAG) begin
                                listening_r <= 1'b1;
                            end else if (cap_data == UNL) begin
                                listening_r <= 1'b0;
                            end else if (cap_data == TAG) begin
                                talking_r   <= 1'b1;
                                listening_r <= 1'b0;
`ifdef IEEE488_SRQ_EN
                                tag_hit     <= 1'b1;
`endif
                            end else if (cap_data[7:5] == 3'b010) begin
                                talking_r <= 1'b0;
                            end else if (cap_data[7:5] == 3'b011 && (listening_r || talking_r)) begin
                                rx_valid_r <= 1'b1;
                                rx_data_r  <= cap_data;
                                rx_eoi_r   <= cap_eoi;
                                rx_atn_r   <= 1'b1;
                            end
                        end else begin
                            rx_valid_r <= 1'b1;
                            rx_data_r  <= cap_data;
                            rx_eoi_r   <= cap_eoi;
                            rx_atn_r   <= 1'b0;
                        end
                    end
                    A_WAITREL: begin
                        if (dav_s) begin
                            ah_state <= A_READY;
                            ndac_r   <= 1'b0;
                            nrfd_r   <= atn_act || rx_free;
                        end
                    end
                    default: ah_state <= A_IDLE;
                endcase
            end
        end
    end

    // Source handshake: present byte, wait for readiness, settle, strobe DAV until all accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_state      <= S_IDLE;
            cnt           <= 8'h00;
            data_o_r      <= 8'hFF;
            dav_r         <= 1'b1;
            eoi_r         <= 1'b1;
            tx_ready_r    <= 1'b0;
            no_listener_r <= 1'b0;
        end else if (ifc_act) begin
            sh_state      <= S_IDLE;
            data_o_r      <= 8'hFF;
            dav_r         <= 1'b1;
            eoi_r         <= 1'b1;
            tx_ready_r    <= 1'b0;
            no_listener_r <= 1'b0;
        end else if (!sh_run) begin
            // ATN or loss of talker address: release lines, byte stays pending
            sh_state   <= S_IDLE;
            data_o_r   <= 8'hFF;
            dav_r      <= 1'b1;
            eoi_r      <= 1'b1;
            tx_ready_r <= 1'b0;
        end else begin
            tx_ready_r <= 1'b0;
            case (sh_state)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        data_o_r <= ~bus.tx_data;
                        eoi_r    <= ~bus.tx_eoi;
                        sh_state <= S_WAITNRFD;
                    end
                end
                S_WAITNRFD: begin
                    if (nrfd_s && ndac_s) begin
                        no_listener_r <= 1'b1;
                    end else if (nrfd_s) begin
                        cnt      <= 8'h00;
                        sh_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 8'(SETTLE_CYCLES - 1)) begin
                        dav_r    <= 1'b0;
                        sh_state <= S_DAV;
                    end else begin
                        cnt <= cnt + 8'h01;
                    end
                end
                S_DAV: begin
                    if (ndac_s) begin
                        dav_r         <= 1'b1;
                        data_o_r      <= 8'hFF;
                        eoi_r         <= 1'b1;
                        tx_ready_r    <= 1'b1;
                        no_listener_r <= 1'b0;
                        sh_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: sh_state <= S_IDLE;
                default:   sh_state <= S_IDLE;
            endcase
        end
    end

`ifdef IEEE488_SRQ_EN
    // Service request: armed on each srq_req rise, disarmed when addressed to talk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srq_req_q <= 1'b0;
            srq_pend  <= 1'b0;
            srq_r     <= 1'b1;
        end else begin
            srq_req_q <= bus.srq_req;
            if (tag_hit)
                srq_pend <= 1'b0;
            else if (bus.srq_req && !srq_req_q)
                srq_pend <= 1'b1;
            srq_r <= ~(bus.srq_req && srq_pend);
        end
    end
    assign bus.ieee488_srq_o = srq_r;
`endif

    assign bus.ieee488_data_o = data_o_r;
    assign bus.ieee488_dav_o  = dav_r;
    assign bus.ieee488_eoi_o  = eoi_r;
    assign bus.ieee488_nrfd_o = nrfd_r;
    assign bus.ieee488_ndac_o = ndac_r;
    assign bus.rx_valid       = rx_valid_r;
    assign bus.rx_data        = rx_data_r;
    assign bus.rx_eoi         = rx_eoi_r;
    assign bus.rx_atn         = rx_atn_r;
    assign bus.tx_ready       = tx_ready_r;
    assign bus.listening      = listening_r;
    assign bus.talking        = talking_r;
    assign bus.no_listener    = no_listener_r;
endmodule

// File: doc/ieee488_device.md
Name: ieee488_device

Overview:
- Peripheral-side IEEE-488 interface: the device end of the bus that the PET's I/O block drives as controller/talker/listener.
- Implements listener/talker addressing, the acceptor handshake (AH) for commands and data, and the source handshake (SH) for talking.
- Presents a byte-stream interface to an internal drive model (disk/printer emulation).
- Sits beside the PET hardware and attaches to its ieee488_* bus ports through the top-level open-collector wired-AND.

Parameters:
- DEV_ADDR, 8, primary address 0..30. Sets LAG = 0x20+DEV_ADDR and TAG = 0x40+DEV_ADDR.
- SETTLE_CYCLES, 16, clk cycles the data lines must be stable before DAV is asserted. Range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ieee488_data_i  in  8  bus data, wire level (0 = asserted bit = logical 1).
- ieee488_data_o  out  8  driven data, wire level. 8'hFF = released.
- ieee488_atn_i, ieee488_ifc_i, ieee488_dav_i, ieee488_eoi_i, ieee488_nrfd_i, ieee488_ndac_i  in  1 each  bus lines, wire level, 0 = asserted.
- ieee488_dav_o, ieee488_eoi_o, ieee488_nrfd_o, ieee488_ndac_o  out  1 each  wire level, 1 = released.
- rx_valid  out  1  received byte available.
- rx_data  out  8  logical (inverted-from-wire) byte.
- rx_eoi  out  1  byte carried EOI.
- rx_atn  out  1  byte is a secondary address (0x60-0x7F) received while addressed.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- tx_valid  in  1  byte to talk.
- tx_data  in  8  logical byte.
- tx_eoi  in  1  assert EOI with this byte.
- tx_ready  out  1  one-cycle pulse: byte was accepted by all listeners (NDAC released).
- listening, talking  out  1 each  addressed state.
- no_listener  out  1  sticky flag, cleared on the next tx_ready.

Behaviour:
- Input synchronisation: every bus input passes through a 2-flop synchroniser. All decisions use the synchronised values, so bus-to-internal latency is 2 clk.
- Reset values:
  - data_o = 8'hFF.
  - dav_o, eoi_o, nrfd_o, ndac_o = 1.
  - rx_valid = 0, tx_ready = 0.
  - listening, talking, no_listener = 0.
  - Both FSMs idle.
- IFC asserted (synchronised ifc = 0), at any time:
  - listening and talking cleared within 1 clk.
  - Both FSMs forced idle; all outputs return to reset values.
  - rx_valid is dropped.
- AH FSM states: A_IDLE, A_READY, A_ACCEPT, A_WAITREL.
  - Active when ATN is asserted, or when listening && ATN released. Otherwise it sits in A_IDLE with nrfd_o = ndac_o = 1.
  - A_READY: ndac_o = 0. nrfd_o = 1 only if the rx buffer is empty (always 1 under ATN).
  - Synchronised DAV = 0 seen while nrfd_o = 1 → capture ~data_i and ~eoi_i, then go to A_ACCEPT.
  - A_ACCEPT (1 clk): nrfd_o = 0.
    - Under ATN: decode the command (below).
    - Otherwise: load the byte into the 1-entry rx buffer (rx_valid = 1, rx_atn = 0).
    - Then go to A_WAITREL.
  - A_WAITREL: ndac_o = 1 while nrfd_o = 0. When DAV = 1 → A_READY (ndac_o = 0 again).
  - nrfd_o stays 0 until rx_valid && rx_ready, unless ATN is asserted (commands never stall).
  - ATN changes mid-byte: the AH restarts at A_READY if still active, else A_IDLE. A half-captured byte is discarded.
- Command decode (logical byte, ATN asserted):
  - LAG → listening = 1.
  - UNL (0x3F) → listening = 0.
  - TAG → talking = 1, listening = 0.
  - Any other talk address 0x40-0x5E, or UNT (0x5F) → talking = 0.
  - 0x60-0x7F while listening || talking → rx buffer with rx_atn = 1.
  - Everything else is ignored.
- SH FSM states: S_IDLE, S_WAITNRFD, S_SETTLE, S_DAV, S_RELEASE.
  - Runs only while talking && ATN released.
  - S_IDLE: when tx_valid → drive data_o = ~tx_data, eoi_o = ~tx_eoi, then go to S_WAITNRFD.
  - S_WAITNRFD: wait for NRFD = 1. If NRFD = 1 && NDAC = 1 simultaneously → set no_listener and stay waiting.
  - S_SETTLE: counter runs SETTLE_CYCLES clk.
  - S_DAV: dav_o = 0, wait for NDAC = 1.
  - S_RELEASE (1 clk): dav_o = 1, data_o = FF, eoi_o = 1, tx_ready = 1. Then return to S_IDLE.
  - ATN asserted in any SH state → release all SH lines within 1 clk and return to S_IDLE. tx_ready is not pulsed; the byte remains pending.
- The device never drives ATN or IFC.

Optional Feature:
- Macro: IEEE488_SRQ_EN.
- Defined:
  - Adds ports srq_req (in, 1) and ieee488_srq_o (out, 1, wire level).
  - ieee488_srq_o = 0 while srq_req = 1.
  - The request is cleared by hardware when the device is addressed as talker (TAG received), until srq_req toggles 0→1 again.
- Undefined: neither port exists; SRQ is never driven.

Test Plan:
- Listen and receive: ATN low, controller sends 0x28 (DEV_ADDR 8), then 0x6F; ATN high; bytes 0x41, 0x42 with EOI on the second → listening = 1; rx stream (0x6F, atn = 1), (0x41, eoi = 0), (0x42, eoi = 1); NDAC/NRFD sequence is legal on every byte.
- Backpressure: keep rx_ready = 0 after the first data byte → nrfd_o stays 0 indefinitely. Raise rx_ready → nrfd_o = 1 within 1 clk of the accept.
- Talk: TAG 0x48, ATN high, tx 0x55 then 0xAA with eoi → data_o = 0xAA and 0x55 (wire level); DAV falls ≥ SETTLE_CYCLES after NRFD high; eoi_o = 0 only on the second byte; two tx_ready pulses.
- No listener: talking, NRFD = NDAC = 1 → no_listener = 1, dav_o stays 1.
- ATN abort: ATN asserted during S_DAV → dav_o, eoi_o, data_o released within 3 clk of the bus edge; no tx_ready; AH asserts ndac_o = 0.
- IFC/reset: pulse IFC while listening and holding a byte, then pulse reset_n low mid-talk → listening = talking = rx_valid = 0; all outputs released asynchronously on reset_n.
